rx_lane_deskew_ctrl: RTL and testbench
======================================

# rx_lane_deskew_ctrl

Receive-side lane alignment controller for the 40GBASE-R PCS. It sits after the four per-lane gearbox/block_sync/alignment_extractor chains and before the descrambler. It measures the inter-lane skew from raw alignment-marker arrivals and programs per-lane delay lines to remove that skew. It then verifies that deskewed markers arrive coincident and periodic, and asserts `align_status` to gate the descrambler and decoder.

## Interface
Parameters:
- `AM_PERIOD`, 16384: blocks between alignment markers on a lane; ≥4.
- `MAX_SKEW`, 7: largest correctable skew in blocks; `DW = $clog2(MAX_SKEW+1)`.
- `LOSS_THRESH`, 3: consecutive bad marker slots before alignment is dropped.

Ports:
- `clk` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: all four lanes present a new 66-bit block this cycle. All counting is gated by it.
- `block_locked` in 4: per-lane block_sync lock.
- `marker_detect` in 4: raw per-lane marker flag, aligned with that lane's current block.
- `am_deskewed` in 4: marker flags after the delay lines.
- `delay_sel` out 4*DW: lane i delay in blocks, at `[i*DW +: DW]`.
- `delay_load` out 1: one-cycle strobe; delay lines capture `delay_sel`.
- `align_status` out 1: lanes deskewed and marker period confirmed.
- `deskew_error` out 1: one-cycle pulse on any alignment failure.

## Operation
States: WAIT_LOCK, WAIT_FIRST, COLLECT, LOAD, VERIFY, ALIGNED.

- **Any state:** if `block_locked != 4'hF`, go to WAIT_LOCK.
  - Clear `align_status`.
  - No error pulse.
  - `delay_sel` holds its value.
- **WAIT_LOCK:** when all four lanes are locked, go to WAIT_FIRST.
- **WAIT_FIRST:** on a valid cycle with `marker_detect != 0`:
  - Record offset 0 for the flagged lanes and set `seen = marker_detect`.
  - Clear `skew_cnt`.
  - If `seen == 4'hF`, go to LOAD; otherwise go to COLLECT.
- **COLLECT:** each valid cycle, increment `skew_cnt`.
  - A lane flagging its first marker records `offset[i] = skew_cnt` (post-increment value) and sets `seen[i]`.
  - If an already-seen lane flags again, pulse `deskew_error` and go to WAIT_FIRST.
  - If `seen == 4'hF`, go to LOAD.
  - If `skew_cnt` reaches `MAX_SKEW` with `seen` still incomplete, pulse `deskew_error` and go to WAIT_FIRST.
- **LOAD:** takes one cycle and is independent of `in_valid`.
  - `delay_sel[i] = max(offset) - offset[i]`, which fits in DW bits because offset ≤ MAX_SKEW.
  - Pulse `delay_load`.
  - Clear `good_cnt` and `phase_valid`, then go to VERIFY.
- **Period counter `pcnt`:** width `$clog2(AM_PERIOD)`.
  - Cleared on each accepted marker; increments on each valid cycle otherwise.
  - A slot is *expected* when `phase_valid` and `pcnt == AM_PERIOD-1`.
  - At an expected slot, `pcnt` wraps to 0 whether or not the marker is good.
- **VERIFY:**
  - First valid cycle with `am_deskewed == 4'hF`: set `phase_valid`, clear `pcnt`, set `good_cnt = 1`.
  - Afterwards, `am_deskewed == 4'hF` at an expected slot increments `good_cnt`. At 2, go to ALIGNED.
  - Failure: a partial `am_deskewed` (nonzero but not F), any marker at an unexpected slot, or `am_deskewed == 0` at an expected slot. Response: pulse `deskew_error` and go to WAIT_FIRST.
- **ALIGNED:** `align_status = 1`.
  - Expected slot with F: clear `bad_cnt`.
  - Expected slot without F, or a nonzero `am_deskewed` off-slot: increment `bad_cnt`. The phase is not re-established.
  - When `bad_cnt` reaches `LOSS_THRESH`:
    - clear `align_status` on the next cycle;
    - pulse `deskew_error`;
    - go to WAIT_FIRST.

## Timing
- **Reset values:**
  - State WAIT_LOCK.
  - `delay_sel = 0`, `delay_load = 0`, `align_status = 0`, `deskew_error = 0`.
  - All counters and `seen` are 0.
- All outputs are registered.
- `delay_load` asserts exactly one cycle after the cycle on which `seen` completes.
- `align_status` rises one cycle after the second good marker in VERIFY.
- `deskew_error` and `delay_load` never assert in the same cycle.
- **Simultaneous events:**
  - Loss of `block_locked` has priority over every marker event.
  - In COLLECT, a repeated lane flag in the same cycle that `seen` completes is an error; LOAD is not entered.
- **Invalid cycles:** when `in_valid = 0`, no counter moves and marker inputs are ignored. The only exception is LOAD, which advances regardless.
- `reset_n` asserted mid-operation returns all outputs to reset values immediately (asynchronously). `delay_sel` is cleared too.

## Test plan
Benches use `AM_PERIOD = 16`, `MAX_SKEW = 7`, `in_valid` constantly 1 unless noted.

1. **Nominal deskew:** raw markers on lanes 0, 3, 1, 2 at relative cycles 0, 1, 2, 5 → `delay_sel = {lane3:4, lane2:0, lane1:3, lane0:5}` and a single `delay_load`. Then drive F on `am_deskewed` every 16 cycles; `align_status` rises one cycle after the second F.
2. **Zero skew:** all four lanes flag in one cycle → LOAD next cycle with all `delay_sel = 0`.
3. **Excess skew:** lane 2 arrives 8 cycles after the first marker → `deskew_error` pulse; `delay_load` never asserted; controller returns to WAIT_FIRST.
4. **Loss:** in ALIGNED, drop `am_deskewed` at 3 consecutive expected slots → `align_status` falls after the third slot with one `deskew_error`. Dropping only 2, then a good slot, keeps `align_status = 1`.
5. **Lock loss and reset:**
   - In ALIGNED, deassert `block_locked[1]` → `align_status = 0` the next cycle, no error pulse; relock → WAIT_FIRST.
   - Assert `reset_n = 0` mid-COLLECT → all outputs 0 asynchronously.
6. **in_valid gaps:** insert `in_valid = 0` every third cycle in scenario 1 → identical `delay_sel` values; period checking counts only valid cycles.

Source files
------------

// File: rtl/rx_lane_deskew_ctrl.sv
// rx_lane_deskew_ctrl
//   Receive-side lane alignment controller for a 4-lane 40GBASE-R PCS.
//   Measures inter-lane skew from raw alignment-marker arrivals, programs
//   the per-lane delay lines, then confirms that deskewed markers arrive
//   coincident and periodic before raising align_status.
//
// Ports
//   clk            core clock
//   reset_n        async active-low reset
//   in_valid       all lanes present a new block this cycle (gates counting)
//   block_locked   per-lane block_sync lock
//   marker_detect  raw per-lane marker flags (before delay lines)
//   am_deskewed    per-lane marker flags after delay lines
//   delay_sel      lane i delay in blocks at [i*DW +: DW]
//   delay_load     one-cycle strobe, delay lines capture delay_sel
//   align_status   lanes deskewed and marker period confirmed
//   deskew_error   one-cycle pulse on any alignment failure

// Per-lane offset capture and delay computation.
module rx_deskew_lane #(
  parameter int DW = 3
) (
  input  logic [DW-1:0] offset,
  input  logic          capture,
  input  logic [DW-1:0] stamp,
  input  logic [DW-1:0] max_off,
  output logic [DW-1:0] offset_nxt,
  output logic [DW-1:0] delay
);
  assign offset_nxt = capture ? stamp : offset;
  // Latest lane gets zero delay; earlier lanes wait for it.
  assign delay      = max_off - offset_nxt;
endmodule

module rx_lane_deskew_ctrl #(
  parameter  int AM_PERIOD   = 16384,
  parameter  int MAX_SKEW    = 7,
  parameter  int LOSS_THRESH = 3,
  localparam int DW          = $clog2(MAX_SKEW+1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [3:0]      block_locked,
  input  logic [3:0]      marker_detect,
  input  logic [3:0]      am_deskewed,
  output logic [4*DW-1:0] delay_sel,
  output logic            delay_load,
  output logic            align_status,
  output logic            deskew_error
);
  localparam int NUM_LANES = 4;
  localparam int PW        = $clog2(AM_PERIOD);
  localparam int BW        = $clog2(LOSS_THRESH+1);

  typedef enum logic [2:0] {
    WAIT_LOCK, WAIT_FIRST, COLLECT, LOAD, VERIFY, ALIGNED
  } state_t;

  state_t                             state;
  logic [NUM_LANES-1:0]               seen;
  logic [DW-1:0]                      skew_cnt;
  logic [NUM_LANES-1:0][DW-1:0]       offset;
  logic [NUM_LANES-1:0][DW-1:0]       delay_sel_q;
  logic [PW-1:0]                      pcnt;
  logic                               phase_valid;
  logic [1:0]                         good_cnt;
  logic [BW-1:0]                      bad_cnt;

  logic [NUM_LANES-1:0][DW-1:0]       offset_nxt;
  logic [NUM_LANES-1:0][DW-1:0]       delay_nxt;
  logic [NUM_LANES-1:0]               capture;
  logic [NUM_LANES-1:0]               seen_nxt;
  logic [NUM_LANES-1:0]               md_rep;
  logic [DW-1:0]                      skew_inc;
  logic [DW-1:0]                      stamp;
  logic [DW-1:0]                      max_off;
  logic [BW-1:0]                      bad_inc;
  logic                               am_full, am_any, slot, ali_bad;

  assign delay_sel = delay_sel_q;
  assign skew_inc  = skew_cnt + 1'b1;
  assign bad_inc   = bad_cnt + 1'b1;
  assign am_full   = &am_deskewed;
  assign am_any    = |am_deskewed;
  assign slot      = phase_valid && (pcnt == PW'(AM_PERIOD-1));
  // In ALIGNED a slot is bad when F is missing, or any marker shows off-slot.
  assign ali_bad   = slot ? !am_full : am_any;
  assign md_rep    = marker_detect & seen;

  always_comb begin
    capture  = '0;
    stamp    = '0;
    seen_nxt = seen | marker_detect;
    if (in_valid && state == WAIT_FIRST) begin
      capture  = marker_detect;
      seen_nxt = marker_detect;
    end else if (in_valid && state == COLLECT) begin
      capture  = marker_detect & ~seen;
      stamp    = skew_inc;
    end
  end

  // Max is taken over next offsets so delays can be registered on the
  // very edge that completes seen.
  always_comb begin
    max_off = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (offset_nxt[i] > max_off) max_off = offset_nxt[i];
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rx_deskew_lane #(.DW(DW)) u_lane (
      .offset     (offset[g]),
      .capture    (capture[g]),
      .stamp      (stamp),
      .max_off    (max_off),
      .offset_nxt (offset_nxt[g]),
      .delay      (delay_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LOCK;
      seen         <= '0;
      skew_cnt     <= '0;
      offset       <= '0;
      delay_sel_q  <= '0;
      pcnt         <= '0;
      phase_valid  <= 1'b0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      delay_load   <= 1'b0;
      align_status <= 1'b0;
      deskew_error <= 1'b0;
    end else begin
      delay_load   <= 1'b0;
      deskew_error <= 1'b0;
      if (block_locked != 4'hF) begin
        // Lock loss beats every marker event; delay_sel is kept.
        state        <= WAIT_LOCK;
        align_status <= 1'b0;
        seen         <= '0;
        skew_cnt     <= '0;
        phase_valid  <= 1'b0;
        good_cnt     <= '0;
        bad_cnt      <= '0;
      end else begin
        unique case (state)
          WAIT_LOCK: state <= WAIT_FIRST;
          WAIT_FIRST: if (in_valid && |marker_detect) begin
            offset   <= offset_nxt;
            seen     <= seen_nxt;
            skew_cnt <= '0;
            if (&seen_nxt) begin
              state       <= LOAD;
              delay_sel_q <= delay_nxt;
              delay_load  <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
          COLLECT: if (in_valid) begin
            skew_cnt <= skew_inc;
            offset   <= offset_nxt;
            seen     <= seen_nxt;
            if (|md_rep) begin
              // Repeat flag wins even if it would also complete seen.
              deskew_error <= 1'b1;
              seen         <= '0;
              state        <= WAIT_FIRST;
            end else if (&seen_nxt) begin
              state       <= LOAD;
              delay_sel_q <= delay_nxt;
              delay_load  <= 1'b1;
            end else if (skew_inc == DW'(MAX_SKEW)) begin
              deskew_error <= 1'b1;
              seen         <= '0;
              state        <= WAIT_FIRST;
            end
          end
          LOAD: begin
            good_cnt    <= '0;
            phase_valid <= 1'b0;
            state       <= VERIFY;
          end
          VERIFY: if (in_valid) begin
            if (!phase_valid) begin
              if (am_full) begin
                phase_valid <= 1'b1;
                pcnt        <= '0;
                good_cnt    <= 2'd1;
              end else if (am_any) begin
                deskew_error <= 1'b1;
                seen         <= '0;
                state        <= WAIT_FIRST;
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end else if (slot) begin
              pcnt <= '0;
              if (am_full) begin
                good_cnt <= good_cnt + 1'b1;
                if (good_cnt == 2'd1) begin
                  state        <= ALIGNED;
                  align_status <= 1'b1;
                  bad_cnt      <= '0;
                end
              end else begin
                deskew_error <= 1'b1;
                seen         <= '0;
                state        <= WAIT_FIRST;
              end
            end else if (am_any) begin
              deskew_error <= 1'b1;
              seen         <= '0;
              state        <= WAIT_FIRST;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          ALIGNED: if (in_valid) begin
            // Phase is never re-established here: pcnt wraps only at slots.
            pcnt <= slot ? '0 : pcnt + 1'b1;
            if (!ali_bad) begin
              if (slot) bad_cnt <= '0;
            end else if (bad_inc >= BW'(LOSS_THRESH)) begin
              align_status <= 1'b0;
              deskew_error <= 1'b1;
              bad_cnt      <= '0;
              seen         <= '0;
              state        <= WAIT_FIRST;
            end else begin
              bad_cnt <= bad_inc;
            end
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_lane_deskew_ctrl.sv
module tb_rx_lane_deskew_ctrl;
  localparam int DW = 3;
  localparam int EV_LOAD = 0, EV_ERR = 1, EV_UP = 2, EV_DN = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [3:0]      block_locked = 4'hF;
  logic [3:0]      marker_detect = 4'h0;
  logic [3:0]      am_deskewed = 4'h0;
  logic [4*DW-1:0] delay_sel;
  logic            delay_load, align_status, deskew_error;

  int   n_chk = 0, n_fail = 0, cyc = 0, gcnt = 0;
  bit   gap = 1'b0;
  logic align_q = 1'b0;

  typedef struct {
    int              kind;
    logic [4*DW-1:0] data;
    int              at;
  } evt_t;
  evt_t q[$];

  rx_lane_deskew_ctrl #(.AM_PERIOD(16), .MAX_SKEW(7), .LOSS_THRESH(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .block_locked  (block_locked),
    .marker_detect (marker_detect),
    .am_deskewed   (am_deskewed),
    .delay_sel     (delay_sel),
    .delay_load    (delay_load),
    .align_status  (align_status),
    .deskew_error  (deskew_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor side: pop the next expected output event and compare.
  task automatic mon(input int k, input logic [4*DW-1:0] d);
    evt_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.at != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                 k, cyc, e.kind, e.at);
      end
      if (k == EV_LOAD) chk("delay_sel", 32'(d), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (delay_load && deskew_error) begin
        n_chk++; n_fail++;
        $display("FAIL load_err_overlap: got both high at cycle %0d, required exclusive", cyc);
      end
      if (delay_load)   mon(EV_LOAD, delay_sel);
      if (deskew_error) mon(EV_ERR, '0);
      if (align_status !== align_q) mon(align_status ? EV_UP : EV_DN, '0);
    end
    align_q = align_status;
  end

  // Stimulus side.
  task automatic expect_evt(input int k, input logic [4*DW-1:0] d);
    evt_t e;
    e.kind = k; e.data = d; e.at = cyc;
    q.push_back(e);
  endtask

  task automatic tick(input logic v, input logic [3:0] lk, input logic [3:0] md, input logic [3:0] am);
    in_valid = v; block_locked = lk; marker_detect = md; am_deskewed = am;
    @(posedge clk); #1;
  endtask

  // One valid cycle; in gap mode an invalid cycle carrying garbage markers
  // is slipped in before every third one.
  task automatic vt(input logic [3:0] md, input logic [3:0] am);
    if (gap) begin
      gcnt++;
      if (gcnt % 3 == 0) tick(1'b0, 4'hF, 4'hF, 4'hF);
    end
    tick(1'b1, 4'hF, md, am);
  endtask

  task automatic period_good();
    repeat (15) vt(4'h0, 4'h0);
    vt(4'h0, 4'hF);
  endtask

  task automatic period_miss();
    repeat (16) vt(4'h0, 4'h0);
  endtask

  // Raw markers: lane0 @0, lane3 @1, lane1 @2, lane2 @5.
  task automatic nominal();
    vt(4'b0001, 4'h0);
    vt(4'b1000, 4'h0);
    vt(4'b0010, 4'h0);
    vt(4'h0, 4'h0);
    vt(4'h0, 4'h0);
    vt(4'b0100, 4'h0);
    expect_evt(EV_LOAD, {3'd4, 3'd0, 3'd3, 3'd5});
    vt(4'h0, 4'h0);           // LOAD cycle
    vt(4'h0, 4'hF);           // first deskewed marker sets phase
    period_good();
    expect_evt(EV_UP, '0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_delay_sel", 32'(delay_sel), 32'h0);
    chk("rst_delay_load", 32'(delay_load), 32'h0);
    chk("rst_align", 32'(align_status), 32'h0);
    chk("rst_err", 32'(deskew_error), 32'h0);
    #1 reset_n = 1'b1;
    vt(4'h0, 4'h0);
    vt(4'h0, 4'h0);

    // nominal deskew then verify
    nominal();
    period_good();

    // two misses then a good slot: stays aligned
    period_miss();
    period_miss();
    period_good();
    // three misses: alignment dropped
    period_miss();
    period_miss();
    period_miss();
    expect_evt(EV_ERR, '0);
    expect_evt(EV_DN, '0);

    // zero skew
    vt(4'hF, 4'h0);
    expect_evt(EV_LOAD, '0);
    vt(4'h0, 4'h0);
    vt(4'h0, 4'hF);
    period_good();
    expect_evt(EV_UP, '0);

    // lock loss in ALIGNED: align drops, no error; relock
    tick(1'b1, 4'b1101, 4'h0, 4'hF);
    expect_evt(EV_DN, '0);
    tick(1'b1, 4'hF, 4'h0, 4'h0);

    // excess skew: lane2 still missing when skew count reaches 7
    vt(4'b0001, 4'h0);
    vt(4'b1010, 4'h0);
    repeat (5) vt(4'h0, 4'h0);
    vt(4'h0, 4'h0);
    expect_evt(EV_ERR, '0);
    // back in WAIT_FIRST: lane2 now leads, the rest one block later
    vt(4'b0100, 4'h0);
    vt(4'b1011, 4'h0);
    expect_evt(EV_LOAD, {3'd0, 3'd1, 3'd0, 3'd0});
    vt(4'h0, 4'h0);
    // partial deskewed marker in VERIFY
    vt(4'h0, 4'b0011);
    expect_evt(EV_ERR, '0);

    // repeat flag in the same cycle that would complete seen
    vt(4'b0011, 4'h0);
    vt(4'b1101, 4'h0);
    expect_evt(EV_ERR, '0);

    // async reset mid-COLLECT
    vt(4'b0001, 4'h0);
    #1 reset_n = 1'b0;
    #1;
    chk("async_delay_sel", 32'(delay_sel), 32'h0);
    chk("async_delay_load", 32'(delay_load), 32'h0);
    chk("async_align", 32'(align_status), 32'h0);
    chk("async_err", 32'(deskew_error), 32'h0);
    tick(1'b0, 4'hF, 4'h0, 4'h0);
    tick(1'b0, 4'hF, 4'h0, 4'h0);
    #1 reset_n = 1'b1;

    // nominal again with in_valid gaps
    gap = 1'b1;
    vt(4'h0, 4'h0);
    vt(4'h0, 4'h0);
    nominal();
    period_good();
    gap = 1'b0;
    tick(1'b1, 4'b0111, 4'h0, 4'h0);
    expect_evt(EV_DN, '0);
    tick(1'b1, 4'hF, 4'h0, 4'h0);

    repeat (3) tick(1'b1, 4'hF, 4'h0, 4'h0);
    chk("events_pending", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
